// File: rtl/spi_master.sv
`timescale 1ns/1ps
// SPI mode-0 master: MSB-first, 1..SPI_MAXLEN bits, SCLK = clk/CLK_DIVIDE.
// Latency: pins follow the accept edge by one clk; done at 1+(2n+1)H, busy low at 1+(2n+2)H.
// Backpressure: start is taken only in IDLE; requests while busy are dropped, not queued.
module spi_master #(
    parameter int CLK_DIVIDE = 100,
    parameter int SPI_MAXLEN = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [$clog2(SPI_MAXLEN):0] n_clks,
    input  logic [SPI_MAXLEN-1:0]       tx_data,
    output logic [SPI_MAXLEN-1:0]       rx_data,
    output logic                        busy,
    output logic                        done,
    output logic                        SCLK,
    output logic                        MOSI,
    input  logic                        MISO,
    output logic                        SS_N
);

    localparam int H  = CLK_DIVIDE / 2;
    localparam int NW = $clog2(SPI_MAXLEN) + 1;
    localparam int TW = $clog2(H + 1);
    localparam logic [TW-1:0] H_LAST = TW'(H - 1);

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GUARD} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tmr_q;
    logic [NW-1:0]         cnt_q;
    logic [NW-1:0]         bit_idx;
    logic [SPI_MAXLEN-1:0] tx_q;
    logic [SPI_MAXLEN-1:0] rx_sr;
    logic                  accept;
    logic                  phase_end;
    logic                  first;
    logic                  mosi_nxt;

    assign accept    = (state_q == IDLE) && start && (n_clks != '0)
                       && (n_clks <= NW'(SPI_MAXLEN));
    assign phase_end = (tmr_q == H_LAST);
    assign first     = (tmr_q == '0);
    // cnt_q is already decremented past the bit just clocked, so cnt_q-1 is the next one
    assign bit_idx   = cnt_q - 1'b1;
    assign mosi_nxt  = |(tx_q & (SPI_MAXLEN'(1) << bit_idx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = LEAD;
            LEAD:    if (phase_end) state_d = HIGH;
            HIGH:    if (phase_end) state_d = (cnt_q != '0) ? LOW : TRAIL;
            LOW:     if (phase_end) state_d = HIGH;
            TRAIL:   if (phase_end) state_d = GUARD;
            GUARD:   if (phase_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pins are decoded from the current state and registered, hence the one-clk lag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
            SS_N    <= 1'b1;
        end else begin
            if (state_d != state_q || state_q == IDLE) begin
                tmr_q <= '0;
            end else begin
                tmr_q <= tmr_q + 1'b1;
            end

            if (accept) begin
                tx_q  <= tx_data;
                cnt_q <= n_clks;
                rx_sr <= '0;
            end else if (state_d == HIGH && state_q != HIGH) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (state_q == HIGH && first) begin
                rx_sr <= (rx_sr << 1) | SPI_MAXLEN'(MISO);
            end

            if ((state_q == LEAD || state_q == LOW) && first) begin
                MOSI <= mosi_nxt;
            end else if (state_q == GUARD || state_q == IDLE) begin
                MOSI <= 1'b0;
            end

            if (state_q == GUARD && first) begin
                rx_data <= rx_sr;
            end

            SCLK <= (state_q == HIGH);
            SS_N <= !(state_q inside {LEAD, HIGH, LOW, TRAIL});
            busy <= (state_q != IDLE);
            done <= (state_q == GUARD) && first;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
// Directed bench for spi_master with CLK_DIVIDE=4 (H=2), SPI_MAXLEN=32 and a mode-0 slave model.
module tb_spi_master;

    localparam int CLK_DIVIDE = 4;
    localparam int SPI_MAXLEN = 32;
    localparam int NW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] n_clks = '0;
    logic [31:0]   tx_data = '0;
    logic [31:0]   rx_data;
    logic          busy, done, SCLK, MOSI, SS_N;
    logic          MISO = 1'b0;

    spi_master #(.CLK_DIVIDE(CLK_DIVIDE), .SPI_MAXLEN(SPI_MAXLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_clks(n_clks),
        .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
        .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS_N(SS_N)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model and pin monitor, evaluated on the quiet clk edge
    int          slave_n = 8;
    logic [31:0] slave_data = '0;
    int          sidx = 0;
    logic [31:0] s_rx = '0;
    int          rise_cnt = 0, done_cnt = 0;
    int          first_rise_cyc = 0, last_fall_cyc = 0, done_cyc = 0;
    int          ssn_rise_cyc = 0, ssn_fall_cyc = 0, busy_fall_cyc = 0;
    logic        p_sclk = 1'b0, p_ssn = 1'b1, p_busy = 1'b0;

    always @(negedge clk) begin
        if (!SS_N && p_ssn) begin
            sidx = slave_n - 1;
            s_rx = '0;
            rise_cnt = 0;
            ssn_fall_cyc = cyc;
        end
        if (SCLK && !p_sclk) begin
            s_rx = {s_rx[30:0], MOSI};
            if (rise_cnt == 0) first_rise_cyc = cyc;
            rise_cnt++;
        end
        if (!SCLK && p_sclk) begin
            last_fall_cyc = cyc;
            sidx--;
        end
        if (SS_N && !p_ssn) ssn_rise_cyc = cyc;
        if (!busy && p_busy) busy_fall_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        MISO = (!SS_N && sidx >= 0) ? (((slave_data >> sidx) & 32'd1) != 32'd0) : 1'b0;
        p_sclk = SCLK;
        p_ssn  = SS_N;
        p_busy = busy;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 1000 && done_cnt < target; i++) step();
        check({tag, " done_seen"}, 32'(done_cnt >= target), 32'd1);
    endtask

    // One transfer from IDLE; exp_done is the done cycle relative to the accept edge
    task automatic do_xfer(input int n, input logic [31:0] tx, input logic [31:0] sd,
                           input logic [31:0] exp_rx, input logic [31:0] exp_srx,
                           input int exp_done, input string tag, output int acc);
        int d0;
        slave_n    = n;
        slave_data = sd;
        n_clks     = NW'(n);
        tx_data    = tx;
        start      = 1'b1;
        acc        = cyc + 1;
        d0         = done_cnt;
        step();
        start = 1'b0;
        step();
        check({tag, " cycle1 ss_n/busy/mosi"}, {29'd0, SS_N, busy, MOSI},
              32'b010 | ((tx >> (n - 1)) & 32'd1));
        wait_done(d0 + 1, tag);
        for (int i = 0; i < 100 && busy; i++) step();
        check({tag, " rx_data"}, rx_data, exp_rx);
        check({tag, " slave_rx"}, s_rx, exp_srx);
        check({tag, " sclk_pulses"}, 32'(rise_cnt), 32'(n));
        check({tag, " done_cycle"}, 32'(done_cyc - acc), 32'(exp_done));
        check({tag, " ss_n_rise_cycle"}, 32'(ssn_rise_cyc - acc), 32'(exp_done));
        check({tag, " busy_fall_cycle"}, 32'(busy_fall_cyc - acc), 32'(exp_done + 2));
        check({tag, " one_done"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1, d0, bad;

        // Reset state
        step(); step(); step();
        check("reset SCLK", {31'd0, SCLK}, 32'd0);
        check("reset SS_N", {31'd0, SS_N}, 32'd1);
        check("reset MOSI", {31'd0, MOSI}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset rx_data", rx_data, 32'd0);
        rst_n = 1'b1;
        step();

        // Full width, then 8-bit proves upper rx bits are cleared
        do_xfer(32, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'hDEADBEEF, 131, "full32", acc);
        step();
        do_xfer(8, 32'h000000A5, 32'h0000003C, 32'h0000003C, 32'h000000A5, 35, "basic8", acc);
        step();
        do_xfer(1, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000001, 7, "single1", acc);
        check("single1 sclk_rise_cycle", 32'(first_rise_cyc - acc), 32'd3);
        check("single1 sclk_fall_cycle", 32'(last_fall_cyc - acc), 32'd5);
        step();

        // Illegal lengths: 0 and SPI_MAXLEN+1
        d0 = done_cnt;
        bad = 0;
        n_clks = 6'd0; start = 1'b1; step(); start = 1'b0;
        n_clks = 6'd33; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!SS_N || busy || done) bad = 1;
            step();
        end
        check("illegal no_pin_activity", 32'(bad), 32'd0);
        check("illegal no_done", 32'(done_cnt - d0), 32'd0);

        // Start pulsed mid-transfer with different data is dropped
        slave_n = 8; slave_data = 32'h69; n_clks = 6'd8; tx_data = 32'h96;
        d0 = done_cnt;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        tx_data = 32'hFF; n_clks = 6'd4; start = 1'b1; step(); start = 1'b0;
        wait_done(d0 + 1, "overlap");
        for (int i = 0; i < 60; i++) step();
        check("overlap one_done", 32'(done_cnt - d0), 32'd1);
        check("overlap rx_data", rx_data, 32'h69);
        check("overlap slave_rx", s_rx, 32'h96);

        // Reset after the 3rd rising SCLK of a 16-bit transfer
        slave_n = 16; slave_data = 32'h1234; n_clks = 6'd16; tx_data = 32'hBEEF;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 200 && !(SS_N == 1'b0 && rise_cnt == 3); i++) step();
        check("midreset reached_3rd_rise", 32'(rise_cnt == 3 && SCLK == 1'b1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset SS_N", {31'd0, SS_N}, 32'd1);
        check("midreset SCLK", {31'd0, SCLK}, 32'd0);
        check("midreset rx_data", rx_data, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset MOSI", {31'd0, MOSI}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        do_xfer(8, 32'h5A, 32'hC3, 32'hC3, 32'h5A, 35, "postreset8", acc);
        step();

        // Back-to-back with start held high
        slave_n = 8; slave_data = 32'h7E; n_clks = 6'd8; tx_data = 32'h81;
        d0 = done_cnt;
        start = 1'b1;
        acc1 = cyc + 1;
        wait_done(d0 + 1, "b2b first");
        check("b2b first rx_data", rx_data, 32'h7E);
        check("b2b first slave_rx", s_rx, 32'h81);
        tx_data = 32'h3C; slave_data = 32'hE7;
        for (int i = 0; i < 50 && SS_N; i++) step();
        start = 1'b0;
        check("b2b ss_n_high_gap", 32'(ssn_fall_cyc - ssn_rise_cyc - 1), 32'd2);
        wait_done(d0 + 2, "b2b second");
        check("b2b second rx_data", rx_data, 32'hE7);
        check("b2b second slave_rx", s_rx, 32'h3C);
        check("b2b second done_cycle", 32'(done_cyc - acc1), 32'd72);
        for (int i = 0; i < 50; i++) step();
        check("b2b two_dones", 32'(done_cnt - d0), 32'd2);
        check("b2b idle_after", {30'd0, SS_N, busy}, 32'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

SPI master that serialises a parallel word onto MOSI and deserialises MISO into a parallel word, driving SCLK and SS_N for the SPI slave test model. It sits between the system-side request logic and the SPI pins, directly upstream of the slave. The link runs in SPI mode 0 (CPOL=0, CPHA=0), MSB first, with a runtime-selectable length of 1..SPI_MAXLEN bits.

## Interface
- CLK_DIVIDE, 100: clk cycles per SCLK period; must be even and ≥2; H = CLK_DIVIDE/2 is the half-period.
- SPI_MAXLEN, 32: maximum transfer length in bits.
- clk  in  1  system clock; all logic runs on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  transfer request; sampled only in IDLE.
- n_clks  in  $clog2(SPI_MAXLEN)+1  transfer length in bits; sampled with start.
- tx_data  in  SPI_MAXLEN  data to send; bit n_clks-1 goes out first; sampled with start.
- rx_data  out  SPI_MAXLEN  received word, right-aligned, upper bits zero; reset value 0.
- busy  out  1  high from the accept cycle through the end of GUARD; reset value 0.
- done  out  1  one-cycle pulse when SS_N deasserts; reset value 0.
- SCLK  out  1  SPI clock, idle low; reset value 0.
- MOSI  out  1  serial data out; reset value 0.
- MISO  in  1  serial data in.
- SS_N  out  1  active-low slave select; reset value 1.

## Operation
- States: IDLE, LEAD, HIGH, LOW, TRAIL, GUARD.
- IDLE:
  - If start=1 and 1 ≤ n_clks ≤ SPI_MAXLEN: latch tx_data and n_clks, set bit counter = n_clks, go to LEAD.
  - A start with n_clks=0 or n_clks>SPI_MAXLEN is ignored: no busy, no done, no pin activity.
- LEAD: SS_N=0, MOSI=tx[n-1], SCLK=0. After H cycles, go to HIGH.
- HIGH:
  - SCLK=1. On entry, shift MISO into rx shift register (LSB end) and decrement the bit counter.
  - After H cycles: go to LOW if the counter is nonzero, else TRAIL.
- LOW: SCLK=0. On entry, MOSI takes the next bit (tx[counter-1]). After H cycles, go to HIGH.
- TRAIL: SCLK=0, MOSI holds the last bit, SS_N still 0. After H cycles, go to GUARD.
- GUARD:
  - On entry: SS_N=1, MOSI=0, done=1 for one cycle, rx_data updated from the shift register (upper bits zero).
  - After H cycles, go to IDLE with busy=0.
  - GUARD guarantees SS_N stays high for at least H cycles between transfers.
- While busy, start is ignored and tx_data/n_clks may change freely.
- rx_data holds its value until the next completed transfer.
- An aborted transfer never updates rx_data.

## Timing
- Cycle 0 is the clk edge where start is accepted. Registered outputs change at the following edges.
- Cycle 1: SS_N falls, MOSI=tx[n-1], busy rises.
- Rising SCLK edge k (k=1..n) occurs at cycle 1+(2k-1)H. MISO is sampled on that same clk edge.
- Falling SCLK edge k occurs at cycle 1+2kH (k=1..n-1). MOSI changes on the same edge.
- SS_N rises and done pulses at cycle 1+(2n+1)H.
- busy falls at cycle 1+(2n+2)H. The earliest next accept is that cycle.
- MOSI is always stable ≥H cycles before each rising SCLK.
- Reset asserted at any time, including mid-transfer:
  - SCLK=0, SS_N=1, MOSI=0, busy=0, done=0, rx_data=0, state IDLE, immediately (asynchronous).
  - The first accept is possible on the first clk edge after rst_n releases.

## Test plan
Bench settings: CLK_DIVIDE=4 (H=2), SPI_MAXLEN=32, slave model attached with matching n_clks.
- Basic 8-bit: n_clks=8, tx=0xA5, slave test_data=0x3C -> 8 SCLK pulses; rx_data=0x0000003C; slave MOSI_reg[7:0]=0xA5; done at cycle 35; busy falls at cycle 37.
- Full width: n_clks=32, tx=0xDEADBEEF, slave 0x12345678 -> rx_data=0x12345678; slave receives 0xDEADBEEF; done at cycle 131.
- Single bit: n_clks=1, tx=0x1, slave bit0=0 -> exactly one SCLK pulse at cycles 3–4; rx_data=0; done at cycle 7.
- Illegal/overlapping start: start with n_clks=0 -> SS_N stays 1, no done. Start pulsed during a transfer -> ignored; exactly one done.
- Reset mid-transfer: n_clks=16, assert rst_n=0 after the 3rd rising SCLK -> SS_N=1, SCLK=0, rx_data=0 before the next clk edge. Then an n_clks=8, tx=0x5A transfer completes correctly.
- Back-to-back: start held high, two 8-bit transfers -> SS_N high exactly 2 cycles between them; both rx values correct; two done pulses.
